// File: rtl/ucode_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ucode_pkg
// Brief    : Shared types, dispatch addresses and control-store contents for
//            the multicycle ARM microprogram sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package ucode_pkg;

    localparam int UPC_BITS = 4;
    localparam int CW_BITS  = 16;

    typedef enum logic [2:0] {
        NEXT  = 3'd0,
        JUMP  = 3'd1,
        DISP1 = 3'd2,
        DISP2 = 3'd3,
        FETCH = 3'd4
    } seq_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } seq_state_e;

    typedef struct packed {
        seq_mode_e             seq_mode;
        logic [UPC_BITS-1:0]   next_adr;
        logic                  mem;
        logic [CW_BITS-1:0]    dp;
    } uinstr_t;

    localparam logic [UPC_BITS-1:0] MEM_ADR   = 4'd2;
    localparam logic [UPC_BITS-1:0] BR_ADR    = 4'd9;
    localparam logic [UPC_BITS-1:0] EXR_ADR   = 4'd6;
    localparam logic [UPC_BITS-1:0] EXI_ADR   = 4'd7;
    localparam logic [UPC_BITS-1:0] LD_ADR    = 4'd3;
    localparam logic [UPC_BITS-1:0] ST_ADR    = 4'd4;
    localparam logic [UPC_BITS-1:0] FAULT_ADR = 4'hF;

    // Control store: fetch, decode, memory path, execute path, branch, fault trap.
    function automatic uinstr_t ucode_word(input logic [UPC_BITS-1:0] adr);
        uinstr_t w;
        w = '{seq_mode: seq_mode_e'(3'd7), next_adr: '0, mem: 1'b0, dp: '0};
        case (adr)
            4'd0:  w = '{seq_mode: NEXT,  next_adr: 4'd0,  mem: 1'b1, dp: 16'h1401};
            4'd1:  w = '{seq_mode: DISP1, next_adr: 4'd0,  mem: 1'b0, dp: 16'h0022};
            4'd2:  w = '{seq_mode: DISP2, next_adr: 4'd0,  mem: 1'b0, dp: 16'h0C40};
            4'd3:  w = '{seq_mode: JUMP,  next_adr: 4'd5,  mem: 1'b1, dp: 16'h0081};
            4'd4:  w = '{seq_mode: FETCH, next_adr: 4'd0,  mem: 1'b1, dp: 16'h0102};
            4'd5:  w = '{seq_mode: FETCH, next_adr: 4'd0,  mem: 1'b0, dp: 16'h0204};
            4'd6:  w = '{seq_mode: JUMP,  next_adr: 4'd8,  mem: 1'b0, dp: 16'h0408};
            4'd7:  w = '{seq_mode: NEXT,  next_adr: 4'd0,  mem: 1'b0, dp: 16'h0810};
            4'd8:  w = '{seq_mode: FETCH, next_adr: 4'd0,  mem: 1'b0, dp: 16'h1020};
            4'd9:  w = '{seq_mode: FETCH, next_adr: 4'd0,  mem: 1'b0, dp: 16'h2040};
            4'd10: w = '{seq_mode: seq_mode_e'(3'd5), next_adr: 4'd0, mem: 1'b0, dp: 16'h0000};
            4'd11: w = '{seq_mode: seq_mode_e'(3'd6), next_adr: 4'd0, mem: 1'b0, dp: 16'h0000};
            4'd15: w = '{seq_mode: JUMP,  next_adr: 4'hF,  mem: 1'b0, dp: 16'h0000};
            default: w = '{seq_mode: seq_mode_e'(3'd7), next_adr: 4'd0, mem: 1'b0, dp: 16'h0000};
        endcase
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ucode_rom.sv
`default_nettype none
// ============================================================================
// Module   : ucode_rom
// Brief    : Combinational control-store lookup, micro-address to microword.
// Revision : 1.0 - initial release
// ============================================================================
module ucode_rom
    import ucode_pkg::*;
(
    input  logic [UPC_BITS-1:0] adr,
    output uinstr_t             uinstr
);

    always_comb begin
        uinstr = ucode_word(adr);
    end

endmodule
`default_nettype wire

// File: rtl/ucode_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ucode_sequencer
// Brief    : Micro-PC sequencer with Op/Funct dispatch, memory handshake stall
//            and timeout watchdog driving the datapath control word.
// Revision : 1.0 - initial release
// ============================================================================
module ucode_sequencer #(
    parameter int               UPC_W     = 4,
    parameter int               CW_W      = 16,
    parameter int               TIMEOUT   = 15,
    parameter logic [UPC_W-1:0] FAULT_ADR = 4'hF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run,
    input  logic [1:0]       op,
    input  logic [5:0]       funct,
    input  logic             mem_ack,
    output logic [UPC_W-1:0] upc,
    output logic [CW_W-1:0]  ctrl,
    output logic             mem_req,
    output logic             instr_done,
    output logic             fault
);
    import ucode_pkg::*;

    localparam int                WAIT_W      = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'(TIMEOUT - 1);

    seq_state_e        r_state;
    logic [UPC_W-1:0]  r_upc;
    logic [WAIT_W-1:0] r_wait;
    logic              r_instr_done;

    uinstr_t           w_uinstr;
    logic [UPC_W-1:0]  w_next_upc;
    logic              w_illegal;
    logic              w_advance;
    logic              w_timeout;
    logic              w_unused_funct;

    ucode_rom u_rom (
        .adr    (r_upc),
        .uinstr (w_uinstr)
    );

    assign w_unused_funct = ^funct[4:1];
    assign w_advance      = ~w_uinstr.mem | mem_ack;
    assign w_timeout      = (r_wait == c_wait_last);

    always_comb begin
        w_next_upc = r_upc + 1'b1;
        w_illegal  = 1'b0;
        case (w_uinstr.seq_mode)
            NEXT:  w_next_upc = r_upc + 1'b1;
            JUMP:  w_next_upc = w_uinstr.next_adr;
            DISP1: begin
                case (op)
                    2'b01:   w_next_upc = MEM_ADR;
                    2'b10:   w_next_upc = BR_ADR;
                    2'b00:   w_next_upc = funct[5] ? EXI_ADR : EXR_ADR;
                    default: begin
                        w_next_upc = FAULT_ADR;
                        w_illegal  = 1'b1;
                    end
                endcase
            end
            DISP2: w_next_upc = funct[0] ? LD_ADR : ST_ADR;
            FETCH: w_next_upc = '0;
            default: begin
                w_next_upc = FAULT_ADR;
                w_illegal  = 1'b1;
            end
        endcase
    end

    // Memory micro-ops only retire on mem_ack; an ack in the watchdog's last cycle still wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_upc        <= '0;
            r_wait       <= '0;
            r_instr_done <= 1'b0;
        end else begin
            r_instr_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (run) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_advance) begin
                        r_wait <= '0;
                        if (w_illegal) begin
                            r_upc   <= FAULT_ADR;
                            r_state <= ST_FAULT;
                        end else begin
                            r_upc        <= w_next_upc;
                            r_instr_done <= (w_uinstr.seq_mode == FETCH);
                        end
                    end else if (w_timeout) begin
                        r_upc   <= FAULT_ADR;
                        r_state <= ST_FAULT;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_FAULT;
                    r_upc   <= FAULT_ADR;
                end
            endcase
        end
    end

    assign upc        = r_upc;
    assign instr_done = r_instr_done;
    assign fault      = (r_state == ST_FAULT);
    assign ctrl       = (r_state == ST_RUN) ? w_uinstr.dp : '0;
    assign mem_req    = (r_state == ST_RUN) & w_uinstr.mem;

endmodule
`default_nettype wire

// File: tb/tb_ucode_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ucode_sequencer
// Brief    : Randomized scoreboard bench for ucode_sequencer against a
//            behavioural microprogram model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ucode_sequencer;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        run;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic        mem_ack;
    logic [3:0]  upc;
    logic [15:0] ctrl;
    logic        mem_req;
    logic        instr_done;
    logic        fault;

    always #5 clk = ~clk;

    ucode_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .run        (run),
        .op         (op),
        .funct      (funct),
        .mem_ack    (mem_ack),
        .upc        (upc),
        .ctrl       (ctrl),
        .mem_req    (mem_req),
        .instr_done (instr_done),
        .fault      (fault)
    );

    typedef struct packed {
        logic [3:0]  upc;
        logic [15:0] ctrl;
        logic        mem_req;
        logic        instr_done;
        logic        fault;
    } obs_t;

    obs_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Microprogram as documented: mode 0..4 = NEXT/JUMP/DISP1/DISP2/FETCH, 5..7 illegal
    int          rom_mode[16];
    int          rom_nadr[16];
    bit          rom_mem[16];
    logic [15:0] rom_dp[16];

    bit m_running, m_fault, m_done;
    int m_upc, m_wait;

    function automatic void set_word(int a, int md, int na, bit mm, logic [15:0] d);
        rom_mode[a] = md;
        rom_nadr[a] = na;
        rom_mem[a]  = mm;
        rom_dp[a]   = d;
    endfunction

    function automatic void init_rom();
        set_word(0,  0, 0,  1, 16'h1401);
        set_word(1,  2, 0,  0, 16'h0022);
        set_word(2,  3, 0,  0, 16'h0C40);
        set_word(3,  1, 5,  1, 16'h0081);
        set_word(4,  4, 0,  1, 16'h0102);
        set_word(5,  4, 0,  0, 16'h0204);
        set_word(6,  1, 8,  0, 16'h0408);
        set_word(7,  0, 0,  0, 16'h0810);
        set_word(8,  4, 0,  0, 16'h1020);
        set_word(9,  4, 0,  0, 16'h2040);
        set_word(10, 5, 0,  0, 16'h0000);
        set_word(11, 6, 0,  0, 16'h0000);
        set_word(12, 7, 0,  0, 16'h0000);
        set_word(13, 7, 0,  0, 16'h0000);
        set_word(14, 7, 0,  0, 16'h0000);
        set_word(15, 1, 15, 0, 16'h0000);
    endfunction

    function automatic void m_reset();
        m_running = 0;
        m_fault   = 0;
        m_done    = 0;
        m_upc     = 0;
        m_wait    = 0;
    endfunction

    // One rising edge of the documented machine.
    function automatic void m_edge(bit rv, logic [1:0] o, logic [5:0] f, bit ack);
        int nxt;
        bit bad;
        nxt = 0;
        bad = 0;
        m_done = 0;
        if (!m_running) begin
            m_running = rv;
            return;
        end
        if (m_fault) return;
        if (!rom_mem[m_upc] || ack) begin
            m_wait = 0;
            case (rom_mode[m_upc])
                0: nxt = (m_upc + 1) % 16;
                1: nxt = rom_nadr[m_upc];
                2: begin
                    if (o == 2'b01)      nxt = 2;
                    else if (o == 2'b10) nxt = 9;
                    else if (o == 2'b00) nxt = f[5] ? 7 : 6;
                    else                 bad = 1;
                end
                3: nxt = f[0] ? 3 : 4;
                4: begin
                    nxt    = 0;
                    m_done = 1;
                end
                default: bad = 1;
            endcase
            if (bad) begin
                m_upc   = 15;
                m_fault = 1;
            end else begin
                m_upc = nxt;
            end
        end else if (m_wait == TIMEOUT - 1) begin
            m_upc   = 15;
            m_fault = 1;
        end else begin
            m_wait = m_wait + 1;
        end
    endfunction

    function automatic obs_t exp_now();
        obs_t e;
        bit   active;
        active       = m_running && !m_fault;
        e.upc        = 4'(m_upc);
        e.ctrl       = active ? rom_dp[m_upc] : 16'h0000;
        e.mem_req    = active && rom_mem[m_upc];
        e.instr_done = m_done;
        e.fault      = m_fault;
        return e;
    endfunction

    function automatic bit ack_for(int delay);
        if (m_running && !m_fault && rom_mem[m_upc]) return (m_wait >= delay);
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic step(input bit rn, input bit rv, input logic [1:0] o,
                        input logic [5:0] f, input bit ack);
        @(posedge clk);
        #1;
        reset_n = rn;
        run     = rv;
        op      = o;
        funct   = f;
        mem_ack = ack;
        if (!rn) m_reset();
        exp_q.push_back(exp_now());
        if (rn) m_edge(rv, o, f, ack);
    endtask

    task automatic run_program(input logic [1:0] o, input logic [5:0] f,
                               input int delay, input int n);
        step(0, 0, o, f, 0);
        step(0, 1, o, f, 1);
        step(1, 1, o, f, ack_for(delay));
        for (int i = 0; i < n; i++) begin
            step(1, 1'($urandom_range(0, 1)), o, f, ack_for(delay));
        end
    endtask

    always @(negedge clk) begin
        obs_t e;
        obs_t a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {upc, ctrl, mem_req, instr_done, fault};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL obs t=%0t actual upc=%0d ctrl=%h mem_req=%b done=%b fault=%b required upc=%0d ctrl=%h mem_req=%b done=%b fault=%b",
                         $time, a.upc, a.ctrl, a.mem_req, a.instr_done, a.fault,
                         e.upc, e.ctrl, e.mem_req, e.instr_done, e.fault);
            end
        end
    end

    initial begin
        logic [1:0] ro;
        logic [5:0] rf;
        init_rom();
        m_reset();
        reset_n = 1'b0;
        run     = 1'b0;
        op      = 2'b00;
        funct   = 6'b0;
        mem_ack = 1'b0;

        // Data-processing register form, load with delayed ack, never-ack timeout,
        // ack on the watchdog's last cycle, illegal op dispatch.
        run_program(2'b00, 6'b001000, 0, 8);
        run_program(2'b01, 6'b000001, 3, 14);
        run_program(2'b01, 6'b000001, 99, 22);
        run_program(2'b00, 6'b100000, 14, 24);
        run_program(2'b11, 6'b010101, 0, 12);
        run_program(2'b01, 6'b000000, 2, 14);
        run_program(2'b10, 6'b000000, 0, 8);

        // Reset asserted mid-wait at the load micro-op.
        step(0, 0, 2'b01, 6'b000001, 0);
        step(1, 1, 2'b01, 6'b000001, 1);
        for (int i = 0; i < 40; i++) begin
            if (m_upc == 3 && m_wait == 2) break;
            step(1, 0, 2'b01, 6'b000001, (rom_mem[m_upc] && m_upc != 3));
        end
        step(0, 0, 2'b01, 6'b000001, 1);
        for (int i = 0; i < 3; i++) step(1, 0, 2'b01, 6'b000001, 1);
        step(1, 1, 2'b01, 6'b000001, ack_for(0));
        for (int i = 0; i < 6; i++) step(1, 0, 2'b01, 6'b000001, ack_for(0));

        for (int ep = 0; ep < 40; ep++) begin
            ro = 2'($urandom_range(0, 3));
            rf = 6'($urandom);
            step(0, 0, ro, rf, 0);
            step(1, 1, ro, rf, ack_for(0));
            for (int i = 0; i < int'($urandom_range(10, 40)); i++) begin
                int dly;
                dly = int'($urandom_range(0, 16));
                if ($urandom_range(0, 5) == 0) begin
                    ro = 2'($urandom_range(0, 3));
                    rf = 6'($urandom);
                end
                if ($urandom_range(0, 60) == 0) step(0, 0, ro, rf, 0);
                else step(1, 1'($urandom_range(0, 1)), ro, rf, ack_for(dly));
            end
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain actual pending=%0d required pending=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
